// File: rtl/fluxo_dados_contador_if.sv
// Command/status bundle between the counting control FSM (master) and its
// datapath responder (slave). The FSM drives the command strobes and the
// target value; the datapath returns completion status and debug state.
interface fluxo_dados_contador_if #(
    parameter int N        = 4,
    parameter int W_CICLOS = 8
);
    // Commands from the FSM
    logic                zera;
    logic                registra;
    logic                conta;
    logic [N-1:0]        dados;

    // Status and debug returned by the datapath
    logic                fim_contador;
    logic [N-1:0]        valor_reg;
    logic [N-1:0]        contagem;
    logic [W_CICLOS-1:0] ciclos;
    logic                erro;

    modport master (
        output zera, registra, conta, dados,
        input  fim_contador, valor_reg, contagem, ciclos, erro
    );

    modport slave (
        input  zera, registra, conta, dados,
        output fim_contador, valor_reg, contagem, ciclos, erro
    );
endinterface

// File: rtl/fluxo_dados_contador.sv
// Datapath for the counting control FSM. Holds the target value, a
// prescaled saturating counter, a completed-run counter and a sticky
// protocol-error flag. fim_contador is combinational so the FSM can leave
// its counting state on the very next edge.
module fluxo_dados_contador #(
    parameter int N        = 4,
    parameter int PRESCALE = 1,
    parameter int W_CICLOS = 8
) (
    input  logic                    clock,
    input  logic                    reset,   // asynchronous, active low
    fluxo_dados_contador_if.slave   bus
);

    // Prescaler needs at least one bit even when every conta cycle is a step.
    localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [N-1:0]        valor_reg_q;
    logic                reg_valido_q;
    logic [N-1:0]        contagem_q, contagem_d;
    logic [PW-1:0]       presc_q,    presc_d;
    logic                fim_q;
    logic [W_CICLOS-1:0] ciclos_q;
    logic                erro_q;

    logic                no_alvo;
    logic                fim_contador;

    // Comparison always uses the currently registered target, so a registra
    // in the same cycle only takes effect from the next one.
    assign no_alvo      = (contagem_q == valor_reg_q);
    assign fim_contador = bus.conta & no_alvo;

    // Target register; reg_valido records that a target has ever been loaded.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_reg_q  <= '0;
            reg_valido_q <= 1'b0;
        end else if (bus.registra) begin
            valor_reg_q  <= bus.dados;
            reg_valido_q <= 1'b1;
        end
    end

    // Counter next state: clear beats count; saturate at target; step once
    // every PRESCALE cycles of conta.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        contagem_d = contagem_q;
        presc_d    = '0;
        if (bus.zera) begin
            contagem_d = '0;
        end else if (bus.conta && !no_alvo) begin
            if (presc_q == PRESC_MAX) begin
                contagem_d = contagem_q + N'(1);
            end else begin
                presc_d    = presc_q + PW'(1);
            end
        end
    end

    // Counter and prescaler registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_q <= '0;
            presc_q    <= '0;
        end else begin
            contagem_q <= contagem_d;
            presc_q    <= presc_d;
        end
    end

    // Run counter: one increment per rising edge of fim_contador, free wrap,
    // deliberately untouched by zera so it accumulates across passes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fim_q    <= 1'b0;
            ciclos_q <= '0;
        end else begin
            fim_q <= fim_contador;
            if (fim_contador && !fim_q) begin
                ciclos_q <= ciclos_q + W_CICLOS'(1);
            end
        end
    end

    // Sticky protocol error: counting before any target was loaded, or the
    // FSM asserting clear and count together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro_q <= 1'b0;
        end else if ((bus.conta && !reg_valido_q) || (bus.zera && bus.conta)) begin
            erro_q <= 1'b1;
        end
    end

    assign bus.fim_contador = fim_contador;
    assign bus.valor_reg    = valor_reg_q;
    assign bus.contagem     = contagem_q;
    assign bus.ciclos       = ciclos_q;
    assign bus.erro         = erro_q;

endmodule

// File: tb/tb_fluxo_dados_contador.sv
// Bench for fluxo_dados_contador: a table of single-cycle vectors on a
// PRESCALE=1 instance, then hand-written multi-cycle sequences for the
// prescaled latency, error flag, run-counter wrap and mid-count reset.
module tb_fluxo_dados_contador;

    logic clock;
    logic reset;

    fluxo_dados_contador_if #(.N(4), .W_CICLOS(8)) bus1 ();
    fluxo_dados_contador_if #(.N(4), .W_CICLOS(8)) bus3 ();

    fluxo_dados_contador #(.N(4), .PRESCALE(1), .W_CICLOS(8)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    fluxo_dados_contador #(.N(4), .PRESCALE(3), .W_CICLOS(8)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Inputs applied for one cycle; expected values are those visible just
    // before the closing edge (state from earlier cycles, fim from this one).
    typedef struct {
        logic       zera;
        logic       registra;
        logic       conta;
        logic [3:0] dados;
        logic       fim;
        logic [3:0] cont;
        logic [3:0] val;
        logic [7:0] cic;
        logic       erro;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic z, input logic r, input logic c,
                                input logic [3:0] d, input logic f,
                                input logic [3:0] ct, input logic [3:0] v,
                                input logic [7:0] cy, input logic e);
        vec_t t;
        t.zera = z; t.registra = r; t.conta = c; t.dados = d;
        t.fim = f; t.cont = ct; t.val = v; t.cic = cy; t.erro = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive1(input logic z, input logic r, input logic c, input logic [3:0] d);
        bus1.zera = z; bus1.registra = r; bus1.conta = c; bus1.dados = d;
    endtask

    task automatic drive3(input logic z, input logic r, input logic c, input logic [3:0] d);
        bus3.zera = z; bus3.registra = r; bus3.conta = c; bus3.dados = d;
    endtask

    task automatic do_reset();
        drive1(0, 0, 0, 0);
        drive3(0, 0, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // One nominal FSM pass on the PRESCALE=1 instance, bounded wait for fim.
    task automatic run_pass(input logic [3:0] d, output bit got);
        got = 1'b0;
        drive1(1, 0, 0, 0); tick();
        drive1(0, 1, 0, d); tick();
        drive1(0, 0, 1, 0);
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            got = bus1.fim_contador;
            tick();
        end
        drive1(0, 0, 0, 0); tick();
    endtask

    initial begin
        bit got;

        // Directed table: basic run to 5, target 0, registra mid-count,
        // zera together with registra.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 5, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0, 5, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 1, 5, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 2, 5, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 3, 5, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 4, 5, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 1, 5, 5, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 5, 5, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 5, 5, 1, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 5, 1, 0);
        vecs[12] = mk(0, 0, 1, 0, 1, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 1, 0, 0, 2, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 2, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 2, 0);
        vecs[16] = mk(0, 1, 0, 4, 0, 0, 0, 2, 0);
        vecs[17] = mk(0, 0, 1, 0, 0, 0, 4, 2, 0);
        vecs[18] = mk(0, 0, 1, 0, 0, 1, 4, 2, 0);
        vecs[19] = mk(0, 0, 1, 0, 0, 2, 4, 2, 0);
        vecs[20] = mk(0, 0, 1, 0, 0, 3, 4, 2, 0);
        vecs[21] = mk(0, 1, 1, 7, 1, 4, 4, 2, 0);
        vecs[22] = mk(0, 0, 1, 0, 0, 4, 7, 3, 0);
        vecs[23] = mk(0, 0, 1, 0, 0, 5, 7, 3, 0);
        vecs[24] = mk(0, 0, 1, 0, 0, 6, 7, 3, 0);
        vecs[25] = mk(0, 0, 1, 0, 1, 7, 7, 3, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 7, 7, 4, 0);
        vecs[27] = mk(1, 1, 0, 3, 0, 7, 7, 4, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 3, 4, 0);

        reset = 1'b0;
        drive1(0, 0, 0, 0);
        drive3(0, 0, 0, 0);
        tick();
        check("rst_contagem",  bus1.contagem, 0);
        check("rst_valor_reg", bus1.valor_reg, 0);
        check("rst_ciclos",    bus1.ciclos, 0);
        check("rst_erro",      bus1.erro, 0);
        check("rst_fim",       bus1.fim_contador, 0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive1(vecs[i].zera, vecs[i].registra, vecs[i].conta, vecs[i].dados);
            #1;
            check($sformatf("vec%0d_fim", i),  bus1.fim_contador, vecs[i].fim);
            check($sformatf("vec%0d_cont", i), bus1.contagem,     vecs[i].cont);
            check($sformatf("vec%0d_val", i),  bus1.valor_reg,    vecs[i].val);
            check($sformatf("vec%0d_cic", i),  bus1.ciclos,       vecs[i].cic);
            check($sformatf("vec%0d_erro", i), bus1.erro,         vecs[i].erro);
            tick();
        end
        drive1(0, 0, 0, 0);

        // PRESCALE=3, target 2: steps every 3 cycles, fim at conta cycle 6,
        // then saturates for 4 more cycles with ciclos incremented once.
        do_reset();
        drive3(1, 0, 0, 0); tick();
        drive3(0, 1, 0, 2); tick();
        drive3(0, 0, 1, 0);
        for (int k = 0; k <= 10; k++) begin
            #1;
            check($sformatf("p3_k%0d_cont", k), bus3.contagem, (k / 3 > 2) ? 2 : k / 3);
            check($sformatf("p3_k%0d_fim", k),  bus3.fim_contador, (k >= 6) ? 1 : 0);
            check($sformatf("p3_k%0d_cic", k),  bus3.ciclos, (k >= 7) ? 1 : 0);
            tick();
        end
        drive3(0, 0, 0, 0);
        check("p3_erro", bus3.erro, 0);

        // Counting before any target load sets the sticky error.
        do_reset();
        drive1(0, 0, 1, 0);
        #1;
        check("err_pre", bus1.erro, 0);
        tick();
        drive1(0, 0, 0, 0);
        #1;
        check("err_set", bus1.erro, 1);
        run_pass(4'd2, got);
        check("err_run_fim_seen", got, 1);
        check("err_sticky", bus1.erro, 1);
        reset = 1'b0;
        #1;
        check("err_cleared_by_reset", bus1.erro, 0);
        tick();
        reset = 1'b1;

        // zera and conta together: clear wins, error set.
        drive1(1, 0, 0, 0); tick();
        drive1(0, 1, 0, 3); tick();
        drive1(0, 0, 1, 0); tick(); tick();
        #1;
        check("zc_cont_before", bus1.contagem, 2);
        check("zc_erro_before", bus1.erro, 0);
        drive1(1, 0, 1, 0); tick();
        drive1(0, 0, 0, 0);
        #1;
        check("zc_cont_after", bus1.contagem, 0);
        check("zc_erro_after", bus1.erro, 1);

        // 256 nominal passes with target 1: ciclos wraps back to 0.
        do_reset();
        for (int p = 0; p < 256; p++) begin
            run_pass(4'd1, got);
            check($sformatf("wrap_p%0d_fim_seen", p), got, 1);
            if (p == 254) check("wrap_cic_255", bus1.ciclos, 255);
        end
        check("wrap_cic_0", bus1.ciclos, 0);
        check("wrap_erro", bus1.erro, 0);

        // Reset mid-count at contagem=3 toward 9: outputs clear before next edge.
        drive1(1, 0, 0, 0); tick();
        drive1(0, 1, 0, 9); tick();
        drive1(0, 0, 1, 0); tick(); tick(); tick();
        #1;
        check("mid_cont_3", bus1.contagem, 3);
        #1;
        reset = 1'b0;
        drive1(0, 0, 0, 0);
        #1;
        check("mid_contagem",  bus1.contagem, 0);
        check("mid_valor_reg", bus1.valor_reg, 0);
        check("mid_ciclos",    bus1.ciclos, 0);
        check("mid_erro",      bus1.erro, 0);
        check("mid_fim",       bus1.fim_contador, 0);
        tick();
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fluxo_dados_contador.md
Name: fluxo_dados_contador

Overview:
Datapath responder for the counting control FSM. It executes the FSM's command strobes and returns the completion status fim_contador:
- zera clears the counter.
- registra latches the target value.
- conta advances the counter.
It also keeps a run counter and a sticky protocol-error flag for debug and verification.

Parameters:
N, 4, width of target value, counter and comparison.
PRESCALE, 1, clock cycles per counter step while conta is high (must be >= 1).
W_CICLOS, 8, width of completed-run counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
zera  in  1  synchronous clear of counter and prescaler.
registra  in  1  load dados into target register.
conta  in  1  count enable.
dados  in  N  target value sampled on registra.
fim_contador  out  1  counter has reached target while conta high (combinational).
valor_reg  out  N  registered target value.
contagem  out  N  current counter value.
ciclos  out  W_CICLOS  number of completed runs.
erro  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, async):
  - valor_reg=0, contagem=0, prescaler=0, ciclos=0, erro=0.
  - reg_valido=0, fim_q=0.
  - fim_contador=0 because it is gated by conta, which the FSM holds at 0 in reset.
- Target register:
  - On a clock edge with registra=1: valor_reg<=dados and reg_valido<=1.
  - Only reset clears reg_valido.
- Counter and prescaler, priority zera > conta:
  - zera=1: contagem<=0, prescaler<=0.
  - Else conta=0: prescaler<=0, contagem holds.
  - Else conta=1 and contagem==valor_reg: contagem saturates (holds), prescaler<=0.
  - Else conta=1: if prescaler==PRESCALE-1, then prescaler<=0 and contagem<=contagem+1; otherwise prescaler<=prescaler+1.
  - Counter never exceeds valor_reg and never wraps.
- fim_contador = conta & (contagem==valor_reg), combinational.
  - The FSM samples it in its counting state and leaves on the next edge.
- Latency:
  - Starting from contagem=0 with conta held high from cycle t, fim_contador rises in cycle t + D*PRESCALE, where D=valor_reg.
  - D=0: fim_contador is high in the first conta cycle.
- Run counter:
  - fim_q<=fim_contador every edge.
  - ciclos increments when fim_contador=1 and fim_q=0 (rising edge of fim); wraps from max to 0.
  - Not cleared by zera.
- erro:
  - Set on any edge where conta=1 and reg_valido=0 (count before target loaded), or where zera=1 and conta=1 together (illegal FSM output).
  - Sticky until reset.
- Simultaneous events:
  - zera+registra: both take effect.
  - registra+conta: this cycle's comparison and increment use the old valor_reg; the new value applies from the next cycle.
  - zera+conta: clear wins and erro is set.
- Reset mid-count: all state returns to reset values immediately, with no partial increment.
- Nominal FSM sequence:
  - zera (1 cycle), then registra (1 cycle), then conta until fim_contador, then 1 idle cycle, then repeat.
  - Each pass adds exactly 1 to ciclos.

Test Plan:
- Reset release, then zera=1 (1 cycle), registra=1 with dados=5 (1 cycle), conta=1 with PRESCALE=1 -> fim_contador low for 5 cycles, high in 6th conta cycle with contagem=5; ciclos=1; erro=0.
- dados=0, registra, then conta -> fim_contador=1 in first conta cycle, contagem stays 0, ciclos increments once.
- PRESCALE=3, dados=2, conta held -> contagem steps at 3-cycle intervals, fim_contador rises 6 cycles after conta rises; hold conta 4 more cycles -> contagem stays 2, ciclos unchanged.
- conta=1 immediately after reset without registra -> erro=1 and stays 1 through later normal runs until reset=0; assert zera+conta in a fresh run -> contagem=0, erro=1.
- Run 256 nominal passes with dados=1, W_CICLOS=8 -> ciclos wraps to 0; mid-count reset=0 when contagem=3, dados=9 -> all outputs 0 asynchronously, before next clock edge.
- registra with dados=7 during conta at contagem=4 (old valor_reg=4) -> fim_contador=1 that cycle; next cycle fim=0, counting resumes to 7.
